// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage pipeline register chain carrying a WIDTH-bit payload.
// Each stage can be held by its stall_req bit. A stall holds that stage and
// every stage below it, and inserts a bubble directly above the highest
// stalled stage. A flush clears every stage on the next edge. stall_cnt counts
// edges with any stall request and saturates at its maximum value.
//
// Handshake: in_valid/in_data are offered at stage 0 and are consumed on a
// rising edge only when in_valid & in_ready. in_ready is low while stage 0 is
// frozen or flush is high. A refused payload is not consumed, so the producer
// keeps offering it until it is accepted.
module pipe_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall_req,
    input  logic                   flush,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH-1:0]       freeze,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] s_q [DEPTH];

    // A stage is frozen when it or any stage above it requests a stall.
    always_comb begin
        freeze = '0;
        for (int k = 0; k < DEPTH; k++) begin
            freeze[k] = |(stall_req >> k);
        end
    end

    assign in_ready = ~freeze[0] & ~flush;

    // Stage 0: flush clears it; when frozen it holds; otherwise it loads the
    // offered payload, or a bubble if nothing is offered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q[0] <= 1'b0;
            s_q[0] <= RESET_VAL;
        end else if (flush) begin
            v_q[0] <= 1'b0;
            s_q[0] <= RESET_VAL;
        end else if (!freeze[0]) begin
            v_q[0] <= in_valid;
            s_q[0] <= in_valid ? in_data : RESET_VAL;
        end
    end

    for (genvar k = 1; k < DEPTH; k++) begin : g_stage
        // Stage k: it holds when frozen. When the stage below is frozen but
        // this one is not, it sits directly above the highest stall and takes
        // a bubble. Otherwise it advances.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v_q[k] <= 1'b0;
                s_q[k] <= RESET_VAL;
            end else if (flush) begin
                v_q[k] <= 1'b0;
                s_q[k] <= RESET_VAL;
            end else if (freeze[k]) begin
                v_q[k] <= v_q[k];
                s_q[k] <= s_q[k];
            end else if (freeze[k-1]) begin
                v_q[k] <= 1'b0;
                s_q[k] <= RESET_VAL;
            end else begin
                v_q[k] <= v_q[k-1];
                s_q[k] <= s_q[k-1];
            end
        end
    end

    // Count edges with any stall request. Flush does not affect the count.
    // The counter saturates at its maximum value and clears only on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((|stall_req) && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Flatten stage payloads; stage k sits at bits [k*WIDTH +: WIDTH].
    always_comb begin
        stage_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_data[k*WIDTH +: WIDTH] = s_q[k];
        end
    end

    assign stage_valid = v_q;
    assign out_valid   = v_q[DEPTH-1];
    assign out_data    = s_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_chain.sv
// Testbench for pipe_chain: directed reset/latency sequence, table of vectors
// for streaming, stall, bubble and flush cases, counter saturation on a
// CNT_W=4 instance, then randomized traffic checked against a stage model.
module tb_pipe_chain;
  localparam int W = 32;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           in_valid;
  logic [W-1:0]   in_data;
  logic [D-1:0]   stall_req;
  logic           flush;
  logic           in_ready, out_valid;
  logic [D-1:0]   stage_valid, freeze;
  logic [D*W-1:0] stage_data;
  logic [W-1:0]   out_data;
  logic [31:0]    stall_cnt;

  logic           s_in_ready, s_out_valid;
  logic [D-1:0]   s_stage_valid, s_freeze;
  logic [D*W-1:0] s_stage_data;
  logic [W-1:0]   s_out_data;
  logic [3:0]     s_stall_cnt;

  pipe_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
    .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
    .out_data(out_data), .freeze(freeze), .stall_cnt(stall_cnt)
  );

  pipe_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .stall_req(stall_req), .flush(flush),
    .stage_valid(s_stage_valid), .stage_data(s_stage_data), .out_valid(s_out_valid),
    .out_data(s_out_data), .freeze(s_freeze), .stall_cnt(s_stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Stage contents as plain arrays. Each edge is applied from the rule list:
  // flush clears everything; stages up to the highest stall hold; the next
  // stage takes a bubble; stages above it shift; stage 0 loads when free.
  logic         mv [D];
  logic [W-1:0] ms [D];
  int           mcnt;

  function automatic int high_stall(input logic [D-1:0] sr);
    int h = -1;
    for (int k = 0; k < D; k++) if (sr[k]) h = k;
    return h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin mv[k] = 1'b0; ms[k] = '0; end
    mcnt = 0;
  endtask

  task automatic model_edge();
    int h = high_stall(stall_req);
    if (stall_req != 0) mcnt++;
    if (flush) begin
      for (int k = 0; k < D; k++) begin mv[k] = 1'b0; ms[k] = '0; end
    end else begin
      for (int k = D - 1; k >= 0; k--) begin
        if (k <= h) begin
          // held
        end else if (k == h + 1 && h >= 0) begin
          mv[k] = 1'b0; ms[k] = '0;
        end else if (k == 0) begin
          mv[0] = in_valid; ms[0] = in_valid ? in_data : '0;
        end else begin
          mv[k] = mv[k-1]; ms[k] = ms[k-1];
        end
      end
    end
  endtask

  task automatic check_pre();
    int h = high_stall(stall_req);
    logic [D-1:0] ef;
    for (int k = 0; k < D; k++) ef[k] = (k <= h);
    chk("in_ready", in_ready, (h < 0) && !flush);
    chk("freeze", freeze, ef);
  endtask

  task automatic check_post();
    logic [D-1:0]   ev;
    logic [D*W-1:0] ed;
    for (int k = 0; k < D; k++) begin ev[k] = mv[k]; ed[k*W +: W] = ms[k]; end
    chk("stage_valid", stage_valid, ev);
    chk("stage_data", stage_data, ed);
    chk("out_valid", out_valid, mv[D-1]);
    chk("out_data", out_data, ms[D-1]);
    chk("stall_cnt", stall_cnt, mcnt);
    chk("stall_cnt_sat", s_stall_cnt, (mcnt > 15) ? 15 : mcnt);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic [D-1:0] sr, input logic fl);
    in_valid = iv; in_data = d; stall_req = sr; flush = fl;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic [D-1:0] sr;
    logic         fl;
    logic         rdy;   // expected in_ready before the edge
    logic [D-1:0] frz;   // expected freeze before the edge
    logic [D-1:0] sv;    // expected stage_valid after the edge
    logic [W-1:0] od;    // expected out_data after the edge
    int           cnt;   // expected stall_cnt after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [W-1:0] d, logic [D-1:0] sr, logic fl,
                              logic rdy, logic [D-1:0] frz, logic [D-1:0] sv,
                              logic [W-1:0] od, int cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.sr = sr; v.fl = fl; v.rdy = rdy; v.frz = frz;
    v.sv = sv; v.od = od; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    // stream 1..5, then drain (stage 3 starts holding A5)
    tbl.push_back(mk(1, 1, 4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(1, 2, 4'b0000, 0, 1, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(1, 3, 4'b0000, 0, 1, 4'b0000, 4'b0111, 0, 0));
    tbl.push_back(mk(1, 4, 4'b0000, 0, 1, 4'b0000, 4'b1111, 1, 0));
    tbl.push_back(mk(1, 5, 4'b0000, 0, 1, 4'b0000, 4'b1111, 2, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 4'b1110, 3, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 4'b1100, 4, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 4'b1000, 5, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 0));
    // fill 1,2,3 then stall stage 1 for two edges: bubble at stage 2
    tbl.push_back(mk(1, 1, 4'b0000, 0, 1, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(1, 2, 4'b0000, 0, 1, 4'b0000, 4'b0011, 0, 0));
    tbl.push_back(mk(1, 3, 4'b0000, 0, 1, 4'b0000, 4'b0111, 0, 0));
    tbl.push_back(mk(1, 4, 4'b0010, 0, 0, 4'b0011, 4'b1011, 1, 1));
    tbl.push_back(mk(1, 4, 4'b0010, 0, 0, 4'b0011, 4'b0011, 0, 2));
    tbl.push_back(mk(1, 4, 4'b0000, 0, 1, 4'b0000, 4'b0111, 0, 2));
    tbl.push_back(mk(1, 5, 4'b0000, 0, 1, 4'b0000, 4'b1111, 2, 2));
    // stall at the last stage for three edges: everything holds
    tbl.push_back(mk(1, 6, 4'b1000, 0, 0, 4'b1111, 4'b1111, 2, 3));
    tbl.push_back(mk(1, 6, 4'b1000, 0, 0, 4'b1111, 4'b1111, 2, 4));
    tbl.push_back(mk(1, 6, 4'b1000, 0, 0, 4'b1111, 4'b1111, 2, 5));
    tbl.push_back(mk(1, 6, 4'b0000, 0, 1, 4'b0000, 4'b1111, 3, 5));
    // flush with a full chain while 0x99 is offered
    tbl.push_back(mk(1, 32'h99, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 5));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 5));
    // flush together with a stall still counts
    tbl.push_back(mk(0, 0, 4'b0001, 1, 0, 4'b0001, 4'b0000, 0, 6));
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #3;
    check_post();

    // reset asserted mid-stream while a stall is active
    @(negedge clk);
    reset = 1'b1;
    drive(1, 7, 4'b0000, 0);
    tick();
    drive(1, 8, 4'b0010, 0);
    tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_valid", stage_valid, 4'b0000);
    chk("async_reset_out", out_data, 32'h0);
    chk("async_reset_cnt", stall_cnt, 32'd0);
    check_post();
    #2;
    reset = 1'b1;

    // A5 accepted at edge 1 reaches the output after edge 4
    drive(1, 32'hA5, 4'b0000, 0);
    #1;
    check_pre();
    tick();
    check_post();
    drive(0, 0, 4'b0000, 0);
    for (int e = 2; e <= 4; e++) begin
      tick();
      check_post();
      if (e == 3) chk("lat_e3_out_valid", out_valid, 1'b0);
      if (e == 4) begin
        chk("lat_e4_out_valid", out_valid, 1'b1);
        chk("lat_e4_out_data", out_data, 32'hA5);
      end
    end

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].sr, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_freeze", i), freeze, tbl[i].frz);
      check_pre();
      tick();
      chk($sformatf("tbl%0d_stage_valid", i), stage_valid, tbl[i].sv);
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("tbl%0d_stall_cnt", i), stall_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_stall_cnt_sat", i), s_stall_cnt, (tbl[i].cnt > 15) ? 15 : tbl[i].cnt);
      check_post();
    end

    // 4-bit counter saturation: 20 stalled edges, flush on every other edge
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h100 + i, 4'b0001, (i % 2) == 1);
      #1;
      check_pre();
      tick();
      chk($sformatf("sat%0d", i), s_stall_cnt, (i + 1 > 15) ? 15 : i + 1);
      check_post();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'b0000, 0);
      tick();
      chk($sformatf("sat_hold%0d", i), s_stall_cnt, 4'd15);
      check_post();
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom,
            ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'b0000,
            $urandom_range(0, 19) == 0);
      #1;
      check_pre();
      tick();
      check_post();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised pipeline-register chain with per-stage stall requests, bubble insertion, global flush and a stall-cycle counter.
- Replaces the fixed, stall-less per-stage pipe registers between IF/ID/EX/MEM/WB in the OpenMIPS core.
- One instance carries a WIDTH-bit bundle through DEPTH stages. Hazard and multi-cycle units hold it by asserting stall_req for the stage they occupy.

Parameters:
WIDTH, 32, bit width of the payload carried per stage
DEPTH, 4, number of register stages (DEPTH >= 2)
RESET_VAL, 0, payload value loaded on reset, flush and bubble insertion (WIDTH bits)
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  new payload offered at stage 0
in_data  input  WIDTH  payload offered at stage 0
in_ready  output  1  chain accepts in_data on this edge
stall_req  input  DEPTH  bit k: contents of stage k must not advance this cycle
flush  input  1  synchronous clear of all stages
stage_valid  output  DEPTH  valid bit of each stage (bit k = stage k)
stage_data  output  DEPTH*WIDTH  flattened stage payloads; stage k at bits [k*WIDTH +: WIDTH]
out_valid  output  1  equals stage_valid[DEPTH-1]
out_data  output  WIDTH  equals payload of stage DEPTH-1
freeze  output  DEPTH  bit k high when stage k holds this cycle
stall_cnt  output  CNT_W  cycles with any stall_req bit set; saturating

Behaviour:
- Reset (reset low, asynchronous, any time including mid-stall):
  - all V[k] = 0, all S[k] = RESET_VAL, stall_cnt = 0.
  - Outputs reflect this immediately.
  - First update is on the first rising edge after reset deasserts.
- Freeze vector (combinational): freeze[k] = OR of stall_req[j] for j >= k. in_ready = ~freeze[0] & ~flush.
- Let h = highest asserted stall_req index. Per edge, with flush low:
  - stages 0..h hold V and S.
  - stage h+1 (if h+1 < DEPTH) loads a bubble: V = 0, S = RESET_VAL.
  - stages above h+1 advance: V[k] <= V[k-1], S[k] <= S[k-1].
  - No stall: all stages k >= 1 advance.
- Stage 0 when not frozen:
  - in_valid = 1: loads V = 1, S = in_data.
  - in_valid = 0: loads V = 0, S = RESET_VAL.
- Stage 0 when frozen: holds; in_data is not consumed (in_ready = 0). The producer keeps offering it.
- Stall at DEPTH-1: whole chain holds; out_valid/out_data are stable; no bubble is generated.
- Multiple stall_req bits: only h matters for bubble placement. Lower bits are redundant, not an error.
- Bubble behaviour is identical whether the stalled stage is valid or invalid.
- Flush:
  - highest priority over stalls and in_valid.
  - next edge: all V = 0, all S = RESET_VAL.
  - in_data on that edge is dropped (in_ready = 0).
- Latency:
  - payload accepted at edge E appears in stage k after edge E+k.
  - out_valid is high after edge E+DEPTH-1, when no stalls occur.
  - Throughput is one payload per cycle.
- stall_cnt:
  - increments by 1 on each edge where |stall_req = 1, including edges where flush is also high.
  - saturates at 2^CNT_W-1 and does not wrap.
  - cleared only by reset.
- No combinational path from in_data to out_data for any DEPTH.

Test Plan (WIDTH=32, DEPTH=4, RESET_VAL=0):
1. Reset low mid-stream with stall_req=4'b0010 -> immediately stage_valid=0, out_data=0, stall_cnt=0. After release, in_data=32'hA5 accepted at edge 1 -> out_valid=1, out_data=32'hA5 after edge 4.
2. Stream 1,2,3,4,5 on consecutive edges, no stalls -> out_data shows 1..5 on consecutive cycles after edges 4..8; in_ready constantly 1.
3. Stages hold 3,2,1 (stage0..2) and stall_req=4'b0010 for 2 edges -> stages 0,1 hold 3,2; in_ready=0; stage2 becomes bubble; freeze=4'b0011; stall_cnt=2.
4. Stall stall_req=4'b1000 for 3 edges -> all stages hold values; out_valid/out_data stable; freeze=4'b1111; in_ready=0.
5. Stages full (1..4) with flush=1 and in_valid=1, in_data=32'h99 on one edge -> next cycle stage_valid=0 and all payloads 0. 32'h99 is not accepted.
6. CNT_W=4, hold stall_req=4'b0001 for 20 edges -> stall_cnt ends at 15 and stays there. Flush concurrent with stall still increments until saturation.
